// File: rtl/sc_mux_arbiter_if.sv
// Requester-side bus of the mux arbiter: request/burst config in, grant/select/status out.
// master = requesters and control FSM, slave = arbiter.
interface sc_mux_arbiter_if #(
    parameter int DATAWIDTH_MUX_SELECTION = 4,
    parameter int DATAWIDTH_BURST         = 4
);
    logic [7:0]                         SC_MUXARB_request_InBUS;
    logic [DATAWIDTH_BURST-1:0]         SC_MUXARB_burstLen_InBUS;
    logic [DATAWIDTH_MUX_SELECTION-1:0] SC_MUXARB_selection_OutBUS;
    logic [7:0]                         SC_MUXARB_grant_OutBUS;
    logic                               SC_MUXARB_busy_Out;
    logic                               SC_MUXARB_done_Out;

    modport master (
        output SC_MUXARB_request_InBUS,
        output SC_MUXARB_burstLen_InBUS,
        input  SC_MUXARB_selection_OutBUS,
        input  SC_MUXARB_grant_OutBUS,
        input  SC_MUXARB_busy_Out,
        input  SC_MUXARB_done_Out
    );

    modport slave (
        input  SC_MUXARB_request_InBUS,
        input  SC_MUXARB_burstLen_InBUS,
        output SC_MUXARB_selection_OutBUS,
        output SC_MUXARB_grant_OutBUS,
        output SC_MUXARB_busy_Out,
        output SC_MUXARB_done_Out
    );
endinterface

// File: rtl/sc_mux_arbiter.sv
// Round-robin burst arbiter driving the 8-channel mux select; 1-cycle request-to-grant, one dead (done) cycle between grants.
// SC_MUXARB_FIXED_PRIORITY_EN selects lowest-index-wins arbitration instead of round-robin.
module sc_mux_arbiter #(
    parameter int DATAWIDTH_MUX_SELECTION = 4,
    parameter int DATAWIDTH_BURST         = 4
) (
    input  logic             SC_MUXARB_CLOCK_50,
    input  logic             SC_MUXARB_RESET_InHigh,
    sc_mux_arbiter_if.slave  arbBus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t                     state, stateNext;
    logic [2:0]                 owner, ownerNext;
    logic [7:0]                 grant, grantNext;
    logic                       done, doneNext;
    logic [DATAWIDTH_BURST-1:0] counter, counterNext;
    logic [2:0]                 winner;
    logic [7:0]                 request;

    assign request = arbBus.SC_MUXARB_request_InBUS;

`ifdef SC_MUXARB_FIXED_PRIORITY_EN
    always_comb begin
        winner = '0;
        for (int i = 7; i >= 0; i--) begin
            if (request[i]) winner = 3'(i);
        end
    end
`else
    logic [2:0] pointer, pointerNext;
    logic [2:0] idx;

    // Scan downwards so the smallest offset from pointer+1 is assigned last and wins.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int k = 8; k >= 1; k--) begin
            idx = pointer + 3'(k);
            if (request[idx]) winner = idx;
        end
    end
`endif

    always_comb begin
        stateNext   = state;
        ownerNext   = owner;
        grantNext   = grant;
        counterNext = counter;
        doneNext    = 1'b0;
`ifndef SC_MUXARB_FIXED_PRIORITY_EN
        pointerNext = pointer;
`endif
        case (state)
            IDLE: begin
                if (request != 8'h00) begin
                    stateNext   = BUSY;
                    ownerNext   = winner;
                    grantNext   = 8'h01 << winner;
                    counterNext = arbBus.SC_MUXARB_burstLen_InBUS;
                end
            end
            BUSY: begin
                if (counter == '0 || !request[owner]) begin
                    stateNext = IDLE;
                    grantNext = 8'h00;
                    doneNext  = 1'b1;
`ifndef SC_MUXARB_FIXED_PRIORITY_EN
                    pointerNext = owner;
`endif
                end else begin
                    counterNext = counter - 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge SC_MUXARB_CLOCK_50) begin
        if (SC_MUXARB_RESET_InHigh) begin
            state   <= IDLE;
            owner   <= '0;
            grant   <= 8'h00;
            done    <= 1'b0;
            counter <= '0;
`ifndef SC_MUXARB_FIXED_PRIORITY_EN
            pointer <= 3'd7;
`endif
        end else begin
            state   <= stateNext;
            owner   <= ownerNext;
            grant   <= grantNext;
            done    <= doneNext;
            counter <= counterNext;
`ifndef SC_MUXARB_FIXED_PRIORITY_EN
            pointer <= pointerNext;
`endif
        end
    end

    // Selection is the owner index, so it holds the last owner through IDLE.
    assign arbBus.SC_MUXARB_selection_OutBUS = DATAWIDTH_MUX_SELECTION'(owner);
    assign arbBus.SC_MUXARB_grant_OutBUS     = grant;
    assign arbBus.SC_MUXARB_busy_Out         = (state == BUSY);
    assign arbBus.SC_MUXARB_done_Out         = done;
endmodule

// File: doc/sc_mux_arbiter.md
Name: sc_mux_arbiter

Overview:
Round-robin arbiter/sequencer that shares the 8-channel, 32-bit bus multiplexer among 8 requesters. It grants one requester at a time for a bounded burst and drives the mux selection bus with the owner's index. It also exposes a one-hot grant, a busy flag and a done pulse to the requesters and the top-level control FSM.

Parameters:
DATAWIDTH_MUX_SELECTION, 4, width of the selection bus driven into the mux; the index is zero-extended, so only values 0..7 are produced.
DATAWIDTH_BURST, 4, width of the burst-length configuration and the internal down-counter.

Ports:
SC_MUXARB_CLOCK_50  input  1  system clock; all logic on its rising edge.
SC_MUXARB_RESET_InHigh  input  1  reset, synchronous, active-high.
SC_MUXARB_request_InBUS  input  8  request line per requester; bit i = requester i = mux channel i.
SC_MUXARB_burstLen_InBUS  input  DATAWIDTH_BURST  burst length minus 1; sampled at grant.
SC_MUXARB_selection_OutBUS  output  DATAWIDTH_MUX_SELECTION  mux channel select (registered).
SC_MUXARB_grant_OutBUS  output  8  one-hot grant (registered); 0 when no owner.
SC_MUXARB_busy_Out  output  1  high while a grant is active.
SC_MUXARB_done_Out  output  1  single-cycle pulse after each grant ends.

Behaviour:
- Clock and reset: one clock, SC_MUXARB_CLOCK_50. Reset SC_MUXARB_RESET_InHigh is synchronous and active-high.
- Reset values, applied on the next clock edge with reset high:
  - state = IDLE, selection = 0, grant = 8'h00, busy = 0, done = 0, counter = 0.
  - last-owner pointer = 7, so requester 0 has first priority after reset.
- State machine: 2 states, IDLE and BUSY.
- IDLE, request == 0: stay in IDLE; all outputs hold, except done, which clears.
- IDLE, request != 0: winner = first set bit scanning cyclically from (pointer+1) mod 8. On the next edge:
  - state = BUSY, grant = 1 << winner, selection = winner, busy = 1, done = 0.
  - counter = burstLen, owner = winner.
  - Request-to-grant latency is 1 cycle.
- BUSY, end condition: counter == 0, OR request[owner] == 0 sampled this cycle. On the next edge:
  - state = IDLE, grant = 0, busy = 0, done = 1 for exactly one cycle, pointer = owner.
- BUSY, otherwise: counter decrements by 1; all outputs hold.
- Maximum busy duration is burstLen+1 cycles. burstLen = 0 gives exactly 1 busy cycle.
- Early release: if request[owner] drops, the cycle in which it is seen low is still a busy cycle; grant falls on the following edge.
- Dead cycle between grants: always exactly one (the done cycle, in IDLE). Arbitration is evaluated during that cycle, so the next grant appears the cycle after done.
- Selection bus:
  - Holds the last owner's index while IDLE; never changes during BUSY.
  - The upper bits above bit 2 are always 0.
- Changes to burstLen during BUSY are ignored.
- Requests from non-owners during BUSY are ignored until the next IDLE cycle.
- Reset asserted mid-burst: aborts the grant with no done pulse; all state returns to reset values.
- Invariants: grant is always 0 or one-hot; busy == (grant != 0); done and busy are never high together.

Optional Feature:
Macro: SC_MUXARB_FIXED_PRIORITY_EN
- Defined: arbitration is fixed priority, lowest set index wins; the pointer is neither used nor updated. All other timing is identical.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
1. Reset held 2 cycles with request = 8'hFF, then request = 0 -> grant = 8'h00, selection = 0, busy = 0, done = 0 throughout.
2. request = 8'h04, burstLen = 3, held -> 1 cycle later: grant = 8'h04, selection = 2, busy high 4 cycles; done pulse 1 cycle; busy rises again 1 cycle after done.
3. request = 8'hFF held, burstLen = 0 -> grants 0x01, 0x02, 0x04 … 0x80, 0x01 in order. Each has 1 busy cycle followed by 1 done cycle.
4. request = 8'h20, burstLen = 15; clear bit 5 on the 3rd busy cycle -> busy high exactly 3 cycles, done on the 4th, selection stays 5.
5. request = 8'h81, burstLen = 7; assert reset on the 2nd busy cycle -> next edge: grant = 0, busy = 0, no done pulse. After reset release, requester 0 is granted first.
6. SC_MUXARB_FIXED_PRIORITY_EN defined, request = 8'h0F held, burstLen = 1 -> every grant is 0x01, selection = 0. Two busy cycles, one done cycle, repeating.
